// File: rtl/bp_me_wb_pkg.sv
// -----------------------------------------------------------------------------
// bp_me_wb_pkg
//   Shared types and constants for the BP memory-endpoint Wishbone arbiter.
//   Contents:
//     state_e               arbiter FSM state {e_idle, e_busy}
//     wb_arb_max_masters_gp largest supported number of Wishbone masters
// -----------------------------------------------------------------------------
package bp_me_wb_pkg;

   typedef enum logic [0:0] {
      e_idle = 1'b0,
      e_busy = 1'b1
   } state_e;

   localparam int wb_arb_max_masters_gp = 8;

endpackage : bp_me_wb_pkg

// File: rtl/bsg_arb_round_robin.sv
// -----------------------------------------------------------------------------
// bsg_arb_round_robin
//   Round-robin winner selection. The search starts at the priority pointer and
//   wraps; the pointer only moves when yumi_i accepts the current winner, and
//   then points just past that winner.
//   Ports:
//     clk_i      clock
//     reset_n_i  synchronous active-low reset (pointer returns to requester 0)
//     reqs_i     request vector
//     grants_o   one-hot winner (combinational), 0 when nothing requests
//     yumi_i     winner accepted this cycle; advance the pointer
// -----------------------------------------------------------------------------
module bsg_arb_round_robin #(
   parameter int width_p = 2
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] reqs_i,
   output logic [width_p-1:0] grants_o,
   input  logic               yumi_i
);

   localparam int ptr_w_lp = (width_p > 1) ? $clog2(width_p) : 1;
   localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(width_p - 1);

   logic [ptr_w_lp-1:0] ptr_q, ptr_d;
   logic [ptr_w_lp-1:0] idx, win;
   logic                found;

   always_comb begin
      grants_o = '0;
      found    = 1'b0;
      win      = '0;
      idx      = '0;
      for (int k = 0; k < width_p; k++) begin
         idx = ptr_w_lp'((int'(ptr_q) + k) % width_p);
         if (!found && reqs_i[idx]) begin
            found         = 1'b1;
            grants_o[idx] = 1'b1;
            win           = idx;
         end
      end
      ptr_d = (win == last_lp) ? '0 : win + ptr_w_lp'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         ptr_q <= '0;
      end else if (yumi_i && found) begin
         ptr_q <= ptr_d;
      end
   end

endmodule : bsg_arb_round_robin

// File: rtl/bsg_mux_one_hot.sv
// -----------------------------------------------------------------------------
// bsg_mux_one_hot
//   AND-OR multiplexer keyed on a one-hot select. An all-zero select yields 0,
//   which the arbiter relies on to park the slave command at zero when idle.
//   Ports:
//     data_i         els_p packed inputs, element i at slice i
//     sel_one_hot_i  one-hot (or zero) select
//     data_o         selected element
// -----------------------------------------------------------------------------
module bsg_mux_one_hot #(
   parameter int width_p = 1,
   parameter int els_p   = 2
) (
   input  logic [els_p*width_p-1:0] data_i,
   input  logic [els_p-1:0]         sel_one_hot_i,
   output logic [width_p-1:0]       data_o
);

   always_comb begin
      data_o = '0;
      for (int i = 0; i < els_p; i++) begin
         if (sel_one_hot_i[i]) begin
            data_o = data_o | data_i[i*width_p +: width_p];
         end
      end
   end

endmodule : bsg_mux_one_hot

// File: rtl/bp_me_wb_arbiter.sv
// -----------------------------------------------------------------------------
// bp_me_wb_arbiter
//   Shares one classic (single-beat, non-pipelined) Wishbone B4 slave port among
//   num_masters_p masters. Round-robin arbitration; a grant is held for the
//   whole WB cycle (while the grantee keeps cyc high) and at least one idle
//   cycle separates consecutive grants.
//
//   Optional feature: define BP_ME_WB_ARB_TIMEOUT_EN to add a stall watchdog
//   that errors out a transfer after timeout_cycles_p un-acked strobe cycles.
//
//   Ports:
//     clk_i, reset_n_i          clock, synchronous active-low reset
//     m_adr_i/m_dat_i/m_sel_i   packed master command fields, master i at slice i
//     m_we_i/m_cyc_i/m_stb_i    per-master control
//     m_dat_o                   slave read data broadcast to all masters
//     m_ack_o / m_err_o         per-master ack / error (error is 0 without watchdog)
//     s_adr_o..s_stb_o          slave command, muxed from the grantee
//     s_dat_i / s_ack_i         slave read data / ack
//     grant_o                   one-hot current grant
// -----------------------------------------------------------------------------
module bp_me_wb_arbiter
   import bp_me_wb_pkg::*;
#(
   parameter int num_masters_p    = 2,
   parameter int data_width_p     = 64,
   parameter int adr_width_p      = 37,
   parameter int timeout_cycles_p = 1024
) (
   input  logic                                  clk_i,
   input  logic                                  reset_n_i,
   input  logic [num_masters_p*adr_width_p-1:0]  m_adr_i,
   input  logic [num_masters_p*data_width_p-1:0] m_dat_i,
   input  logic [num_masters_p*(data_width_p/8)-1:0] m_sel_i,
   input  logic [num_masters_p-1:0]              m_we_i,
   input  logic [num_masters_p-1:0]              m_cyc_i,
   input  logic [num_masters_p-1:0]              m_stb_i,
   output logic [data_width_p-1:0]               m_dat_o,
   output logic [num_masters_p-1:0]              m_ack_o,
   output logic [num_masters_p-1:0]              m_err_o,
   output logic [adr_width_p-1:0]                s_adr_o,
   output logic [data_width_p-1:0]               s_dat_o,
   output logic [(data_width_p/8)-1:0]           s_sel_o,
   output logic                                  s_we_o,
   output logic                                  s_cyc_o,
   output logic                                  s_stb_o,
   input  logic [data_width_p-1:0]               s_dat_i,
   input  logic                                  s_ack_i,
   output logic [num_masters_p-1:0]              grant_o
);

   localparam int sel_width_lp = data_width_p / 8;
   // Per-master command bundle: {adr, dat, sel, we, cyc, stb}
   localparam int cmd_width_lp = adr_width_p + data_width_p + sel_width_lp + 3;

   state_e                              state_q, state_d;
   logic [num_masters_p-1:0]            grant_q, grant_d;
   logic [num_masters_p-1:0]            req;
   logic [num_masters_p-1:0]            rr_grants;
   logic                                rr_yumi;
   logic [num_masters_p*cmd_width_lp-1:0] cmd_flat;
   logic [cmd_width_lp-1:0]             cmd_sel;
   logic                                g_cyc, g_stb;
   logic                                timeout_fire;

   assign req = m_cyc_i & m_stb_i;

   // Winner selection; pointer advances only when a grant is actually taken.
   bsg_arb_round_robin #(
      .width_p (num_masters_p)
   ) u_rr (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .reqs_i    (req),
      .grants_o  (rr_grants),
      .yumi_i    (rr_yumi)
   );

   for (genvar i = 0; i < num_masters_p; i++) begin : g_cmd
      assign cmd_flat[i*cmd_width_lp +: cmd_width_lp] = {
         m_adr_i[i*adr_width_p +: adr_width_p],
         m_dat_i[i*data_width_p +: data_width_p],
         m_sel_i[i*sel_width_lp +: sel_width_lp],
         m_we_i[i], m_cyc_i[i], m_stb_i[i]
      };
   end

   // grant_q is zero in e_idle, so the muxed slave command is all-zero there.
   bsg_mux_one_hot #(
      .width_p (cmd_width_lp),
      .els_p   (num_masters_p)
   ) u_cmd_mux (
      .data_i        (cmd_flat),
      .sel_one_hot_i (grant_q),
      .data_o        (cmd_sel)
   );

   assign {s_adr_o, s_dat_o, s_sel_o, s_we_o, g_cyc, g_stb} = cmd_sel;
   assign s_stb_o = g_stb;
   assign m_dat_o = s_dat_i;
   assign grant_o = grant_q;

   // Ack is gated by the outgoing cyc/stb, which filters spurious slave acks
   // and acks arriving after the grantee abandoned its cycle.
   assign m_ack_o = grant_q & {num_masters_p{s_ack_i & s_cyc_o & s_stb_o}};

`ifdef BP_ME_WB_ARB_TIMEOUT_EN
   localparam int cnt_w_lp = ($clog2(timeout_cycles_p) + 1 > 10) ?
                             ($clog2(timeout_cycles_p) + 1) : 10;
   localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(timeout_cycles_p - 1);

   logic [cnt_w_lp-1:0] cnt_q;

   // Held at zero while idle so it is clear on entry to e_busy.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         cnt_q <= '0;
      end else if ((state_q == e_idle) || s_ack_i) begin
         cnt_q <= '0;
      end else if (g_cyc && g_stb) begin
         cnt_q <= cnt_q + cnt_w_lp'(1);
      end
   end

   assign timeout_fire = (state_q == e_busy) && g_cyc && g_stb && !s_ack_i &&
                         (cnt_q == cnt_last_lp);
   assign m_err_o      = grant_q & {num_masters_p{timeout_fire}};
`else
   assign timeout_fire = 1'b0;
   assign m_err_o      = '0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_yumi = 1'b0;
      s_cyc_o = g_cyc;
      case (state_q)
         e_idle: begin
            if (|req) begin
               state_d = e_busy;
               grant_d = rr_grants;
               rr_yumi = 1'b1;
            end
         end
         e_busy: begin
            // Release always passes through e_idle, giving the one-cycle gap.
            if (!g_cyc) begin
               state_d = e_idle;
               grant_d = '0;
            end else if (timeout_fire) begin
               s_cyc_o = 1'b0;
               state_d = e_idle;
               grant_d = '0;
            end
         end
         default: begin
            state_d = e_idle;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= e_idle;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   always_ff @(posedge clk_i) begin
      assert ((num_masters_p >= 2) && (num_masters_p <= wb_arb_max_masters_gp))
         else $error("num_masters_p out of range");
      assert ((data_width_p == 8) || (data_width_p == 16) ||
              (data_width_p == 32) || (data_width_p == 64))
         else $error("illegal data_width_p");
      assert (timeout_cycles_p >= 2)
         else $error("timeout_cycles_p too small");
      if (reset_n_i) begin
         assert ($onehot0(grant_q)) else $error("grant_o not onehot0");
      end
   end

endmodule : bp_me_wb_arbiter

// File: tb/tb_bp_me_wb_arbiter.sv
module tb_bp_me_wb_arbiter;

   localparam int N  = 2;
   localparam int DW = 64;
   localparam int AW = 37;
   localparam int SW = DW / 8;

   logic            clk_i = 1'b0;
   logic            reset_n_i;
   logic [N*AW-1:0] m_adr_i;
   logic [N*DW-1:0] m_dat_i;
   logic [N*SW-1:0] m_sel_i;
   logic [N-1:0]    m_we_i, m_cyc_i, m_stb_i;
   logic [DW-1:0]   m_dat_o;
   logic [N-1:0]    m_ack_o, m_err_o;
   logic [AW-1:0]   s_adr_o;
   logic [DW-1:0]   s_dat_o;
   logic [SW-1:0]   s_sel_o;
   logic            s_we_o, s_cyc_o, s_stb_o;
   logic [DW-1:0]   s_dat_i;
   logic            s_ack_i;
   logic [N-1:0]    grant_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   bp_me_wb_arbiter #(
      .num_masters_p    (N),
      .data_width_p     (DW),
      .adr_width_p      (AW),
      .timeout_cycles_p (16)
   ) dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .m_adr_i   (m_adr_i),
      .m_dat_i   (m_dat_i),
      .m_sel_i   (m_sel_i),
      .m_we_i    (m_we_i),
      .m_cyc_i   (m_cyc_i),
      .m_stb_i   (m_stb_i),
      .m_dat_o   (m_dat_o),
      .m_ack_o   (m_ack_o),
      .m_err_o   (m_err_o),
      .s_adr_o   (s_adr_o),
      .s_dat_o   (s_dat_o),
      .s_sel_o   (s_sel_o),
      .s_we_o    (s_we_o),
      .s_cyc_o   (s_cyc_o),
      .s_stb_o   (s_stb_o),
      .s_dat_i   (s_dat_i),
      .s_ack_i   (s_ack_i),
      .grant_o   (grant_o)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_m(input int i, input logic c, input logic s, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] sel);
      m_cyc_i[i] = c;
      m_stb_i[i] = s;
      m_we_i[i]  = w;
      m_adr_i[i*AW +: AW] = a;
      m_dat_i[i*DW +: DW] = d;
      m_sel_i[i*SW +: SW] = sel;
   endtask

   task automatic req(input int i, input logic on);
      m_cyc_i[i] = on;
      m_stb_i[i] = on;
   endtask

   logic [DW-1:0] rd_data [3];
   int g;

   initial begin
      rd_data[0] = 64'h11;
      rd_data[1] = 64'h22;
      rd_data[2] = 64'h33;

      reset_n_i = 1'b0;
      m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
      m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;
      s_dat_i = '0; s_ack_i = 1'b0;
      repeat (3) cyc();
      settle();
      check("rst_grant", 64'(grant_o), 64'h0);
      check("rst_scyc",  64'(s_cyc_o), 64'h0);
      check("rst_sstb",  64'(s_stb_o), 64'h0);
      check("rst_ack",   64'(m_ack_o), 64'h0);
      check("rst_err",   64'(m_err_o), 64'h0);
      reset_n_i = 1'b1;
      cyc();

      // 1: single write from master 0, slave acks two cycles after grant
      set_m(0, 1'b1, 1'b1, 1'b1, 37'h100, 64'hDEADBEEF, 8'hFF);
      settle();
      check("t1_scyc_req_cycle", 64'(s_cyc_o), 64'h0);
      cyc();
      check("t1_scyc", 64'(s_cyc_o), 64'h1);
      check("t1_sstb", 64'(s_stb_o), 64'h1);
      check("t1_sadr", 64'(s_adr_o), 64'h100);
      check("t1_sdat", 64'(s_dat_o), 64'hDEADBEEF);
      check("t1_ssel", 64'(s_sel_o), 64'hFF);
      check("t1_swe",  64'(s_we_o),  64'h1);
      check("t1_grant", 64'(grant_o), 64'h1);
      check("t1_noack", 64'(m_ack_o), 64'h0);
      cyc();
      cyc();
      s_ack_i = 1'b1;
      settle();
      check("t1_ack", 64'(m_ack_o), 64'h1);
      cyc();
      s_ack_i = 1'b0;
      req(0, 1'b0);
      settle();
      check("t1_rel_scyc", 64'(s_cyc_o), 64'h0);
      cyc();
      check("t1_idle_grant", 64'(grant_o), 64'h0);

      // 2: both masters request continuously; pointer now at master 1
      set_m(0, 1'b1, 1'b1, 1'b1, 37'h200, 64'hA0, 8'h0F);
      set_m(1, 1'b1, 1'b1, 1'b0, 37'h300, 64'hB1, 8'hF0);
      for (int k = 0; k < 8; k++) begin
         g = (k + 1) % 2;
         settle();
         check("t2_idle_grant", 64'(grant_o), 64'h0);
         check("t2_idle_scyc",  64'(s_cyc_o), 64'h0);
         cyc();
         check("t2_grant", 64'(grant_o), 64'(1 << g));
         check("t2_sadr",  64'(s_adr_o), (g == 0) ? 64'h200 : 64'h300);
         check("t2_swe",   64'(s_we_o),  (g == 0) ? 64'h1 : 64'h0);
         cyc();
         s_ack_i = 1'b1;
         settle();
         check("t2_ack", 64'(m_ack_o), 64'(1 << g));
         cyc();
         s_ack_i = 1'b0;
         req(g, 1'b0);
         settle();
         check("t2_rel_scyc", 64'(s_cyc_o), 64'h0);
         cyc();
         req(g, 1'b1);
      end
      req(0, 1'b0);
      req(1, 1'b0);
      cyc();

      // 3: master 1 holds cyc for three reads while master 0 waits
      req(1, 1'b1);
      cyc();
      req(0, 1'b1);
      for (int b = 0; b < 3; b++) begin
         s_ack_i = 1'b1;
         s_dat_i = rd_data[b];
         settle();
         check("t3_grant", 64'(grant_o), 64'h2);
         check("t3_ack",   64'(m_ack_o), 64'h2);
         check("t3_mdat",  64'(m_dat_o), 64'(rd_data[b]));
         cyc();
      end
      s_ack_i = 1'b0;
      req(1, 1'b0);
      settle();
      check("t3_rel_grant", 64'(grant_o), 64'h2);
      check("t3_rel_scyc",  64'(s_cyc_o), 64'h0);
      cyc();
      s_ack_i = 1'b1;
      settle();
      check("t3_gap_grant", 64'(grant_o), 64'h0);
      check("t3_spur_ack",  64'(m_ack_o), 64'h0);
      cyc();
      s_ack_i = 1'b0;
      settle();
      check("t3_m0_grant", 64'(grant_o), 64'h1);
      check("t3_m0_sadr",  64'(s_adr_o), 64'h200);
      req(0, 1'b0);
      cyc();
      cyc();

      // 4: master 0 abandons before the slave acks
      req(0, 1'b1);
      cyc();
      check("t4_scyc", 64'(s_cyc_o), 64'h1);
      cyc();
      req(0, 1'b0);
      s_ack_i = 1'b1;
      settle();
      check("t4_drop_scyc", 64'(s_cyc_o), 64'h0);
      check("t4_drop_ack",  64'(m_ack_o), 64'h0);
      cyc();
      check("t4_idle_grant", 64'(grant_o), 64'h0);
      check("t4_late_ack",   64'(m_ack_o), 64'h0);
      s_ack_i = 1'b0;
      cyc();

      // 5: reset while busy; pointer returns to master 0
      req(0, 1'b1);
      cyc();
      check("t5_busy_grant", 64'(grant_o), 64'h1);
      reset_n_i = 1'b0;
      req(1, 1'b1);
      s_ack_i = 1'b1;
      cyc();
      check("t5_rst_grant", 64'(grant_o), 64'h0);
      check("t5_rst_scyc",  64'(s_cyc_o), 64'h0);
      check("t5_rst_sstb",  64'(s_stb_o), 64'h0);
      check("t5_rst_ack",   64'(m_ack_o), 64'h0);
      reset_n_i = 1'b1;
      s_ack_i = 1'b0;
      cyc();
      check("t5_first_grant", 64'(grant_o), 64'h1);
      req(0, 1'b0);
      req(1, 1'b0);
      cyc();
      cyc();

`ifdef BP_ME_WB_ARB_TIMEOUT_EN
      // 6: slave never acks; watchdog fires on the 16th stall cycle
      req(0, 1'b1);
      cyc();
      req(1, 1'b1);
      for (int c = 1; c <= 16; c++) begin
         settle();
         check("t6_err",  64'(m_err_o), (c == 16) ? 64'h1 : 64'h0);
         check("t6_scyc", 64'(s_cyc_o), (c == 16) ? 64'h0 : 64'h1);
         cyc();
      end
      check("t6_idle_grant", 64'(grant_o), 64'h0);
      check("t6_idle_err",   64'(m_err_o), 64'h0);
      cyc();
      check("t6_next_grant", 64'(grant_o), 64'h2);
      req(0, 1'b0);
      req(1, 1'b0);
      cyc();
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_bp_me_wb_arbiter
